// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: bit-serial A - B - Bin, LSB first, one bit per clock; `define SUB_OVF_EN adds signed overflow output ovf
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
`ifdef SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             Bout
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, shadow_q, shadow_d, diff_q;
  logic [IW-1:0]    idx_q;
  logic             br_q, br_d, d_bit, busy_q, done_q, bout_q;
`ifdef SUB_OVF_EN
  logic             ovf_q;
  assign ovf = ovf_q;
`endif
  assign busy = busy_q;
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
    return {(~a & b) | (~(a ^ b) & br), a ^ b ^ br};
  endfunction
  // one full-subtractor stage on the current bit, merged into the shadow result
  always_comb begin
    {br_d, d_bit} = full_sub(a_q[idx_q], b_q[idx_q], br_q);
    shadow_d = shadow_q;
    shadow_d[idx_q] = d_bit;
  end
  // control FSM with registered outputs; Diff/Bout only change on entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      idx_q    <= '0;
      shadow_q <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q      <= A;
          b_q      <= B;
          br_q     <= Bin;
          idx_q    <= '0;
          shadow_q <= '0;
          busy_q   <= 1'b1;
          state_q  <= RUN;
        end
        RUN: begin
          shadow_q <= shadow_d;
          br_q     <= br_d;
          idx_q    <= idx_q + IW'(1);
          if (idx_q == IW'(WIDTH - 1)) begin
            diff_q  <= shadow_d;
            bout_q  <= br_d;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef SUB_OVF_EN
            ovf_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (shadow_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb_serial_ripple_subtractor: scoreboard bench for serial_ripple_subtractor (WIDTH=4)
module tb_serial_ripple_subtractor;
  localparam int W = 4;
  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         busy, done, Bout;
  logic [W-1:0] Diff;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif
  exp_t         sb[$];
  exp_t         e_m;
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .Diff(Diff),
`ifdef SUB_OVF_EN
    .ovf(ovf),
`endif
    .Bout(Bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t e;
    int   r;
    r    = int'(a) - int'(b) - int'(bin);
    e.d  = W'(r);
    e.bo = r < 0;
    e.ov = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e_m = sb.pop_front();
        check("diff", 32'(Diff), 32'(e_m.d));
        check("bout", 32'(Bout), 32'(e_m.bo));
`ifdef SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(e_m.ov));
`endif
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int cyc, bcnt, d0;
    bit got;
    d0 = done_cnt;
    @(posedge clk); #1;
    A = a; B = b; Bin = bin; start = 1'b1;
    sb.push_back(model(a, b, bin));
    @(posedge clk); #1;
    start = 1'b0;
    bcnt = int'(busy);
    got = 1'b0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      bcnt += int'(busy);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("latency", got ? cyc : 99, W);
    @(posedge clk); #1;
    bcnt += int'(busy);
    check("busy_cycles", bcnt, W + 1);
    check("idle_after", 32'(busy), 0);
    check("one_done", done_cnt - d0, 1);
  endtask

  initial begin
    int d0, n;
    int t[3];
    #2 rst_n = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_diff", 32'(Diff), 0);
    check("rst_bout", 32'(Bout), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_op(4'd9, 4'd3, 1'b0);
    run_op(4'd3, 4'd9, 1'b0);
    run_op(4'd0, 4'd0, 1'b1);
    run_op(4'd8, 4'd1, 1'b0);
    run_op(4'd5, 4'd2, 1'b0);
    run_op(4'd7, 4'd7, 1'b1);
    run_op(4'd15, 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) run_op(W'($urandom), W'($urandom), 1'($urandom));
    // start pulsed again mid-RUN must be ignored
    d0 = done_cnt;
    @(posedge clk); #1;
    A = 4'd12; B = 4'd5; Bin = 1'b0; start = 1'b1;
    sb.push_back(model(4'd12, 4'd5, 1'b0));
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    A = 4'd1; B = 4'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("ignore_done", done_cnt - d0, 1);
    // asynchronous reset mid-RUN abandons the operation
    d0 = done_cnt;
    @(posedge clk); #1;
    A = 4'd9; B = 4'd3; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_diff", 32'(Diff), 0);
    check("midrst_bout", 32'(Bout), 0);
    check("midrst_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("midrst_no_done", done_cnt - d0, 0);
    run_op(4'd7, 4'd2, 1'b0);
    // start held high: one result every W+2 cycles
    d0 = done_cnt;
    @(posedge clk); #1;
    A = 4'd15; B = 4'd15; Bin = 1'b0; start = 1'b1;
    repeat (3) sb.push_back(model(4'd15, 4'd15, 1'b0));
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(posedge clk); #1;
      if (done) begin
        t[n] = i;
        n++;
        if (n == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", n, 3);
    check("b2b_gap1", t[1] - t[0], W + 2);
    check("b2b_gap2", t[2] - t[1], W + 2);
    repeat (10) @(posedge clk);
    #1;
    check("b2b_total", done_cnt - d0, 3);
    check("b2b_idle", 32'(busy), 0);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end
endmodule
